// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle between the decode/execute controls, the PC stage and instruction memory.
// master is the PC stage's view; slave is the view of the pipeline/memory around it.
interface pc_next_unit_if;
   logic [31:0] PCimm;
   logic [31:0] ALUres;
   logic        Branch;
   logic        BrTaken;
   logic        Jump;
   logic        JumpReg;
   logic        stall;
   logic        if_ready;
   logic [31:0] PC;
   logic [31:0] PC4;
   logic        if_req;
   logic        redirect;
   logic        trap;

   modport master (
      input  PCimm, ALUres, Branch, BrTaken, Jump, JumpReg, stall, if_ready,
      output PC, PC4, if_req, redirect, trap
   );

   modport slave (
      output PCimm, ALUres, Branch, BrTaken, Jump, JumpReg, stall, if_ready,
      input  PC, PC4, if_req, redirect, trap
   );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC selection, fetch request handshake and
// misaligned-target trap generation.
module pc_next_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input logic            clk,
   input logic            rst,
   pc_next_unit_if.master bus
);

   typedef enum logic [1:0] {StBoot, StFetch, StTrap} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        redirect_q, redirect_d;

   logic [31:0] pc_plus4;
   logic [31:0] jalr_target;
   logic [31:0] target;
   logic        nonseq;
   logic        misaligned;
   logic        fire;

   always_comb begin
      pc_plus4    = pc_q + 32'd4;
      jalr_target = bus.ALUres & ~32'd1;
      fire        = (state_q == StFetch) & bus.if_ready & ~bus.stall;
      nonseq      = bus.JumpReg | bus.Jump | (bus.Branch & bus.BrTaken);

      if (bus.JumpReg) begin
         target = jalr_target;
      end else if (bus.Jump || (bus.Branch && bus.BrTaken)) begin
         target = bus.PCimm;
      end else begin
         target = pc_plus4;
      end

      // bit0 is only ever set on a PCimm target; both bits count as misaligned
      misaligned = nonseq & (|target[1:0]);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect_d = 1'b0;

      case (state_q)
         StBoot: state_d = StFetch;
         StTrap: state_d = StFetch;
         StFetch: begin
            if (fire) begin
               if (misaligned) begin
                  pc_d    = TRAP_VECTOR;
                  state_d = StTrap;
               end else begin
                  pc_d       = target;
                  redirect_d = nonseq;
               end
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VECTOR;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
      end
   end

   assign bus.PC       = pc_q;
   assign bus.PC4      = pc_plus4;
   assign bus.if_req   = (state_q == StFetch);
   assign bus.redirect = redirect_q;
   assign bus.trap     = (state_q == StTrap);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed vector table plus randomized run against a behavioural next-PC model.
module tb_pc_next_unit;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic clk;
   logic rst;
   pc_next_unit_if bus ();

   pc_next_unit #(
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pcimm;
      logic [31:0] alures;
      logic        br;
      logic        taken;
      logic        jmp;
      logic        jr;
      logic        stall;
      logic        rdy;
      logic [31:0] pc;
      logic        req;
      logic        red;
      logic        trp;
   } vec_t;

   vec_t vq[$];

   int checks = 0;
   int errors = 0;

   // reference model: expected observable outputs after the next edge
   logic [31:0] m_pc;
   logic        m_req, m_red, m_trap;

   task automatic add(input logic r, input logic [31:0] pcimm, input logic [31:0] alures,
                      input logic br, input logic taken, input logic jmp, input logic jr,
                      input logic stall, input logic rdy, input logic [31:0] pc,
                      input logic req, input logic red, input logic trp);
      vec_t v;
      v.rst = r; v.pcimm = pcimm; v.alures = alures; v.br = br; v.taken = taken;
      v.jmp = jmp; v.jr = jr; v.stall = stall; v.rdy = rdy;
      v.pc = pc; v.req = req; v.red = red; v.trp = trp;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst         = v.rst;
      bus.PCimm   = v.pcimm;
      bus.ALUres  = v.alures;
      bus.Branch  = v.br;
      bus.BrTaken = v.taken;
      bus.Jump    = v.jmp;
      bus.JumpReg = v.jr;
      bus.stall   = v.stall;
      bus.if_ready = v.rdy;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      bit          jumped;
      if (rst) begin
         m_pc = RV; m_req = 0; m_red = 0; m_trap = 0;
      end else if (!m_req) begin
         // boot and trap cycles both fall through to fetching
         m_req = 1; m_red = 0; m_trap = 0;
      end else begin
         m_red = 0; m_trap = 0;
         if (bus.if_ready && !bus.stall) begin
            jumped = 1;
            if (bus.JumpReg) tgt = bus.ALUres - (bus.ALUres % 2);
            else if (bus.Jump || (bus.Branch && bus.BrTaken)) tgt = bus.PCimm;
            else begin
               tgt = m_pc + 4;
               jumped = 0;
            end
            if (jumped && (tgt % 4) != 0) begin
               m_pc = TV; m_req = 0; m_trap = 1;
            end else begin
               m_pc = tgt; m_red = jumped;
            end
         end
      end
   endtask

   task automatic compare_outputs(input string tag, input logic [31:0] pc, input logic req,
                                  input logic red, input logic trp);
      check({tag, ".PC"}, bus.PC, pc);
      check({tag, ".PC4"}, bus.PC4, pc + 32'd4);
      check({tag, ".if_req"}, {31'd0, bus.if_req}, {31'd0, req});
      check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, red});
      check({tag, ".trap"}, {31'd0, bus.trap}, {31'd0, trp});
   endtask

   initial begin
      vec_t v;
      //   rst pcimm         alures        br tk jp jr st rd  exp_pc        rq rd tr
      add(1, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        1, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h4,        1, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h8,        1, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'hC,        1, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h10,       1, 0, 0);
      add(0, 32'h40,       32'h0,        1, 1, 0, 0, 0, 1, 32'h40,       1, 1, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h44,       1, 0, 0);
      add(0, 32'h80,       32'h0,        1, 0, 0, 0, 0, 1, 32'h48,       1, 0, 0);
      add(0, 32'h80,       32'h203,      0, 0, 1, 1, 0, 1, 32'h100,      0, 0, 1);
      add(0, 32'h400,      32'h0,        0, 0, 1, 0, 0, 1, 32'h100,      1, 0, 0);
      add(0, 32'h20,       32'h0,        0, 0, 1, 0, 0, 1, 32'h20,       1, 1, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 32'h20,       1, 0, 0);
      add(0, 32'h300,      32'h0,        0, 0, 1, 0, 0, 0, 32'h20,       1, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 32'h20,       1, 0, 0);
      add(0, 32'h300,      32'h0,        0, 0, 1, 0, 1, 1, 32'h20,       1, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h24,       1, 0, 0);
      add(0, 32'hFFFF_FFFC, 32'h0,       0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        1, 0, 0);
      add(0, 32'h42,       32'h0,        0, 0, 1, 0, 0, 1, 32'h100,      0, 0, 1);
      add(1, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        1, 0, 0);
      add(0, 32'h11,       32'h0,        1, 1, 0, 0, 0, 1, 32'h100,      0, 0, 1);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h100,      1, 0, 0);
      add(0, 32'h0,        32'h501,      0, 0, 0, 1, 0, 1, 32'h500,      1, 1, 0);
      add(0, 32'h600,      32'h0,        1, 1, 0, 0, 1, 1, 32'h500,      1, 0, 0);
      add(1, 32'h600,      32'h0,        1, 1, 0, 0, 1, 1, 32'h0,        0, 0, 0);
      add(0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        1, 0, 0);

      v = vq[0];
      drive(v);
      m_pc = RV; m_req = 0; m_red = 0; m_trap = 0;

      foreach (vq[i]) begin
         drive(vq[i]);
         model_step();
         @(posedge clk);
         #1;
         compare_outputs($sformatf("vec%0d", i), vq[i].pc, vq[i].req, vq[i].red, vq[i].trp);
      end

      // randomized run against the model, starting from a reset
      rst = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      compare_outputs("rnd_reset", m_pc, m_req, m_red, m_trap);
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         bus.if_ready = ($urandom_range(0, 3) != 0);
         bus.stall    = ($urandom_range(0, 4) == 0);
         bus.Branch   = ($urandom_range(0, 3) == 0);
         bus.BrTaken  = $urandom_range(0, 1) == 1;
         bus.Jump     = ($urandom_range(0, 5) == 0);
         bus.JumpReg  = ($urandom_range(0, 5) == 0);
         bus.PCimm    = $urandom();
         if ($urandom_range(0, 3) != 0) bus.PCimm = bus.PCimm & ~32'd3;
         bus.ALUres   = $urandom();
         if ($urandom_range(0, 2) != 0) bus.ALUres = bus.ALUres & ~32'd2;
         model_step();
         @(posedge clk);
         #1;
         compare_outputs($sformatf("rnd%0d", n), m_pc, m_req, m_red, m_trap);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
